// File: rtl/vga_pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_pll_ctrl_pkg
// Shared definitions for the display PLL lock supervisor:
//   - state_e      : 3-bit FSM state encoding (also driven out on state_o)
//   - DEF_*        : default parameter values for vga_pll_ctrl
//   - SYNC_STAGES  : number of flops in the asynchronous-input synchronizer
// -----------------------------------------------------------------------------
package vga_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 10;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEF_MAX_RETRIES         = 3;
  localparam int unsigned DEF_CNT_W               = 16;
  localparam int unsigned DEF_RTY_W               = 2;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/vga_pll_ctrl_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Generic flop-chain synchronizer (SYNC_STAGES deep, 2 by default) for
// asynchronous status inputs. Synchronous active-low reset clears every stage.
// Ports:
//   clk_i   : destination clock
//   rst_ni  : synchronous active-low reset
//   d_i     : asynchronous input
//   q_o     : synchronized output (SYNC_STAGES edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff
  import vga_pll_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_q <= '{default: '0};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/vga_pll_ctrl.sv
// -----------------------------------------------------------------------------
// vga_pll_ctrl
// Lock supervisor and reset sequencer for the 33 MHz display PLL.
// Pulses the PLL reset, waits for lock with a timeout, retries a bounded number
// of times, requires lock to be stable before releasing the display reset, and
// re-sequences on lock loss or on force_relock.
// Ports:
//   refclk       : 50 MHz reference clock (only clock)
//   rst_n        : synchronous active-low reset
//   pll_locked   : PLL locked flag, asynchronous to refclk
//   force_relock : single-cycle request to restart sequencing
//   pll_rst      : PLL reset, active-high
//   disp_rst_n   : display-path reset, active-low, refclk domain
//   pll_ready    : high only in RUN
//   pll_fail     : high only in FAIL
//   retry_cnt    : attempts consumed since last RUN / reset
//   state_o      : current FSM state encoding (debug)
// Handshake: none; force_relock is a level sampled every edge and takes effect
// on the edge where it is high (priority below rst_n only).
// -----------------------------------------------------------------------------
module vga_pll_ctrl
  import vga_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W               = DEF_CNT_W,
  parameter int unsigned RTY_W               = DEF_RTY_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             disp_rst_n,
  output logic             pll_ready,
  output logic             pll_fail,
  output logic [RTY_W-1:0] retry_cnt,
  output logic [2:0]       state_o
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRIES);

  // ---------------------------------------------------------------------------
  // Lock input synchronizer
  // ---------------------------------------------------------------------------
  logic locked_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;

  logic pll_rst_q, disp_rst_n_q, pll_ready_q, pll_fail_q;

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q      <= S_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_rst_q    <= 1'b1;
      disp_rst_n_q <= 1'b0;
      pll_ready_q  <= 1'b0;
      pll_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      // Outputs are decoded from the next state so they move on the same
      // edge as state_q, with no extra cycle of lag.
      pll_rst_q    <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      disp_rst_n_q <= (state_d == S_RUN);
      pll_ready_q  <= (state_d == S_RUN);
      pll_fail_q   <= (state_d == S_FAIL);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: force_relock > lock loss / timeout > count done.
  // Every terminal count compare leaves its state, so cnt never wraps.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    if (force_relock) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABILIZE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_LIMIT) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET_PLL;
              retry_d = retry_q + RTY_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_STABILIZE: begin
          // A dropout restarts the lock wait (fresh timeout window) but is not
          // charged as a retry: the PLL did lock, it just was not clean yet.
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        S_RUN: begin
          if (!locked_s) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
          end
        end

        S_FAIL: begin
          state_d = S_FAIL;
        end

        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  assign pll_rst    = pll_rst_q;
  assign disp_rst_n = disp_rst_n_q;
  assign pll_ready  = pll_ready_q;
  assign pll_fail   = pll_fail_q;
  assign retry_cnt  = retry_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_vga_pll_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_pll_ctrl
// Directed bench for vga_pll_ctrl with small parameters
// (pulse 4, stable 8, timeout 20, 2 retries). Each step advances one refclk
// edge, samples 1 ns later, and compares the full output vector against the
// hand-derived state and retry count.
// -----------------------------------------------------------------------------
module tb_vga_pll_ctrl;

  localparam int RST_P = 4;
  localparam int STB_P = 8;
  localparam int TO_P  = 20;
  localparam int MAX_R = 2;

  localparam logic [2:0] ST_RST  = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_STAB = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       disp_rst_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  always #10 refclk = ~refclk;

  vga_pll_ctrl #(
    .RST_PULSE_CYCLES    (RST_P),
    .LOCK_STABLE_CYCLES  (STB_P),
    .LOCK_TIMEOUT_CYCLES (TO_P),
    .MAX_RETRIES         (MAX_R),
    .CNT_W               (16),
    .RTY_W               (2)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .disp_rst_n   (disp_rst_n),
    .pll_ready    (pll_ready),
    .pll_fail     (pll_fail),
    .retry_cnt    (retry_cnt),
    .state_o      (state_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Expected {state, pll_rst, disp_rst_n, pll_ready, pll_fail, retry}
  function automatic logic [8:0] exp_vec(input logic [2:0] st, input logic [1:0] rt);
    logic [3:0] o;
    case (st)
      ST_RST:  o = 4'b1000;
      ST_WAIT: o = 4'b0000;
      ST_STAB: o = 4'b0000;
      ST_RUN:  o = 4'b0110;
      ST_FAIL: o = 4'b1001;
      default: o = 4'bxxxx;
    endcase
    return {st, o, rt};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver / checker tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] rt);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {state_o, pll_rst, disp_rst_n, pll_ready, pll_fail, retry_cnt};
    exp = exp_vec(st, rt);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d rst/disp_n/rdy/fail=%b retry=%0d, expected state=%0d rst/disp_n/rdy/fail=%b retry=%0d",
             tag, obs[8:6], obs[5:2], obs[1:0], exp[8:6], exp[5:2], exp[1:0]);
    end
  endtask

  task automatic steps(input string tag, input int n, input logic [2:0] st, input logic [1:0] rt);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), st, rt);
    end
  endtask

  // Starting just after RESET_PLL entry with lock absent: one full attempt.
  task automatic attempt(input string tag, input logic [1:0] rt, input bit last);
    steps({tag, "_pulse"}, RST_P - 1, ST_RST, rt);
    steps({tag, "_wait"}, TO_P, ST_WAIT, rt);
    tick();
    if (last) chk({tag, "_to_fail"}, ST_FAIL, rt);
    else      chk({tag, "_to_retry"}, ST_RST, rt + 2'd1);
  endtask

  // Starting just after WAIT_LOCK entry with locked_s low: lock and reach RUN.
  task automatic lock_to_run(input string tag, input logic [1:0] rt);
    pll_locked = 1'b1;
    steps({tag, "_sync"}, 2, ST_WAIT, rt);
    steps({tag, "_stab"}, STB_P, ST_STAB, rt);
    steps({tag, "_run"}, 1, ST_RUN, 2'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    tick();
    tick();
    chk("reset_state", ST_RST, 2'd0);

    // 1. Clean bring-up: pll_rst high 4 cycles, lock at cycle 10 of WAIT_LOCK
    rst_n = 1'b1;
    steps("t1_pulse", RST_P - 1, ST_RST, 2'd0);
    steps("t1_wait", 10, ST_WAIT, 2'd0);
    lock_to_run("t1", 2'd0);

    // 4. Lock loss in RUN: 3 edges to RESET_PLL, no retry charged, re-lock
    pll_locked = 1'b0;
    steps("t4_loss_sync", 2, ST_RUN, 2'd0);
    steps("t4_loss", 1, ST_RST, 2'd0);
    steps("t4_pulse", RST_P - 1, ST_RST, 2'd0);
    steps("t4_wait", 1, ST_WAIT, 2'd0);
    lock_to_run("t4_relock", 2'd0);

    // 5a. force_relock from RUN
    force_relock = 1'b1;
    steps("t5_force_run", 1, ST_RST, 2'd0);
    force_relock = 1'b0;
    pll_locked   = 1'b0;

    // 3. Glitchy lock with one retry already consumed
    attempt("t3_first", 2'd0, 1'b0);
    steps("t3_pulse", RST_P - 1, ST_RST, 2'd1);
    steps("t3_wait", 1, ST_WAIT, 2'd1);
    pll_locked = 1'b1;
    steps("t3_sync", 2, ST_WAIT, 2'd1);
    steps("t3_stab_pre", 6, ST_STAB, 2'd1);   // stable count now 5
    pll_locked = 1'b0;
    steps("t3_glitch", 2, ST_STAB, 2'd1);     // dropout still in synchronizer
    pll_locked = 1'b1;
    steps("t3_drop", 1, ST_WAIT, 2'd1);       // beats the count-7 completion
    steps("t3_resync", 1, ST_WAIT, 2'd1);
    steps("t3_stab", STB_P, ST_STAB, 2'd1);
    steps("t3_run", 1, ST_RUN, 2'd0);

    // 2. Timeout/retry to FAIL
    pll_locked = 1'b0;
    steps("t2_loss_sync", 2, ST_RUN, 2'd0);
    steps("t2_loss", 1, ST_RST, 2'd0);
    attempt("t2_a0", 2'd0, 1'b0);
    attempt("t2_a1", 2'd1, 1'b0);
    attempt("t2_a2", 2'd2, 1'b1);
    steps("t2_fail_hold", 30, ST_FAIL, 2'd2);

    // 5b. force_relock from FAIL
    force_relock = 1'b1;
    steps("t5_force_fail", 1, ST_RST, 2'd0);
    force_relock = 1'b0;

    // 5c. force_relock on the WAIT_LOCK timeout edge
    steps("t5c_pulse", RST_P - 1, ST_RST, 2'd0);
    steps("t5c_wait", TO_P, ST_WAIT, 2'd0);
    force_relock = 1'b1;
    steps("t5c_force_vs_timeout", 1, ST_RST, 2'd0);
    force_relock = 1'b0;

    // 6. Reset during STABILIZE with a retry outstanding
    attempt("t6_first", 2'd0, 1'b0);
    steps("t6_pulse", RST_P - 1, ST_RST, 2'd1);
    steps("t6_wait", 1, ST_WAIT, 2'd1);
    pll_locked = 1'b1;
    steps("t6_sync", 2, ST_WAIT, 2'd1);
    steps("t6_stab", 3, ST_STAB, 2'd1);
    rst_n = 1'b0;
    steps("t6_reset", 1, ST_RST, 2'd0);
    rst_n = 1'b1;
    steps("t6_re_pulse", RST_P - 1, ST_RST, 2'd0);
    steps("t6_re_wait", 1, ST_WAIT, 2'd0);
    steps("t6_re_stab", STB_P, ST_STAB, 2'd0);
    steps("t6_re_run", 1, ST_RUN, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
